// File: rtl/vga_timing_gen_prog.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen_prog
// Brief    : Run-time programmable raster timing generator. Produces sync,
//            look-ahead active-video flag, pixel coordinates, line/frame
//            strobes and a frame counter. New timings are staged and only
//            take effect on a frame boundary.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen_prog #(
    parameter int CW          = 11,
    parameter int H_SYNC      = 96,
    parameter int H_ACT_START = 144,
    parameter int H_ACT_LEN   = 640,
    parameter int H_TOTAL     = 800,
    parameter int V_SYNC      = 2,
    parameter int V_ACT_START = 35,
    parameter int V_ACT_LEN   = 480,
    parameter int V_TOTAL     = 525,
    parameter int HS_POL      = 0,
    parameter int VS_POL      = 0,
    parameter int LOOKAHEAD   = 1,
    parameter int FRAME_CW    = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_en,
    input  logic                i_cfg_wr,
    input  logic [8*CW-1:0]     i_cfg_data,
    output logic                o_cfg_busy,
    output logic                o_cfg_err,
    output logic                o_hs,
    output logic                o_vs,
    output logic                o_active_video_area,
    output logic [CW-1:0]       o_x,
    output logic [CW-1:0]       o_y,
    output logic                o_line_start,
    output logic                o_frame_start,
    output logic [FRAME_CW-1:0] o_frame_cnt
);

    // Field order matches the config word: h_sync sits in the LSBs.
    typedef struct packed {
        logic [CW-1:0] v_total;
        logic [CW-1:0] v_act_len;
        logic [CW-1:0] v_act_start;
        logic [CW-1:0] v_sync;
        logic [CW-1:0] h_total;
        logic [CW-1:0] h_act_len;
        logic [CW-1:0] h_act_start;
        logic [CW-1:0] h_sync;
    } timing_t;

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_PENDING = 1'b1
    } cfg_state_t;

    localparam timing_t c_DEFAULT = '{
        v_total:     CW'(V_TOTAL),
        v_act_len:   CW'(V_ACT_LEN),
        v_act_start: CW'(V_ACT_START),
        v_sync:      CW'(V_SYNC),
        h_total:     CW'(H_TOTAL),
        h_act_len:   CW'(H_ACT_LEN),
        h_act_start: CW'(H_ACT_START),
        h_sync:      CW'(H_SYNC)
    };
    localparam logic [CW-1:0] c_LOOK     = CW'(LOOKAHEAD);
    localparam logic [CW:0]   c_LOOK_EXT = (CW+1)'(LOOKAHEAD);
    localparam logic          c_HS_POL   = 1'(HS_POL);
    localparam logic          c_VS_POL   = 1'(VS_POL);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    cfg_state_t          r_state;
    timing_t             r_shadow;
    timing_t             r_stage;
    logic                r_busy;
    logic                r_err;
    logic [CW-1:0]       r_h;
    logic [CW-1:0]       r_v;
    logic [FRAME_CW-1:0] r_frame_cnt;
    logic                r_hs;
    logic                r_vs;
    logic                r_act;
    logic [CW-1:0]       r_x;
    logic [CW-1:0]       r_y;
    logic                r_h_zero;
    logic                r_hv_zero;

    // ------------------------------------------------------------------
    // Config validation (sums carried one bit wider to avoid wrap)
    // ------------------------------------------------------------------
    timing_t      w_cfg_in;
    logic         w_cfg_ok;
    logic         w_wr_ok;
    logic [CW:0]  w_in_h_end;
    logic [CW:0]  w_in_v_end;

    assign w_cfg_in   = timing_t'(i_cfg_data);
    assign w_in_h_end = {1'b0, w_cfg_in.h_act_start} + {1'b0, w_cfg_in.h_act_len};
    assign w_in_v_end = {1'b0, w_cfg_in.v_act_start} + {1'b0, w_cfg_in.v_act_len};
    assign w_cfg_ok   = (w_cfg_in.h_sync < w_cfg_in.h_act_start)
                     && (w_in_h_end <= {1'b0, w_cfg_in.h_total})
                     && (c_LOOK_EXT <= {1'b0, w_cfg_in.h_act_start})
                     && (w_cfg_in.v_sync < w_cfg_in.v_act_start)
                     && (w_in_v_end <= {1'b0, w_cfg_in.v_total})
                     && (w_cfg_in.h_act_len != '0)
                     && (w_cfg_in.v_act_len != '0);
    assign w_wr_ok    = i_cfg_wr && w_cfg_ok;

    // ------------------------------------------------------------------
    // Next raster position and the timing that governs it
    // ------------------------------------------------------------------
    logic          w_h_last;
    logic          w_v_last;
    logic          w_wrap;
    logic          w_apply;
    timing_t       w_tim;
    logic [CW-1:0] w_h_nxt;
    logic [CW-1:0] w_v_nxt;
    logic [CW:0]   w_hp;
    logic [CW:0]   w_h_beg;
    logic [CW:0]   w_h_end;
    logic [CW:0]   w_v_beg;
    logic [CW:0]   w_v_end;
    logic          w_act_nxt;

    assign w_h_last = (r_h == r_shadow.h_total - CW'(1));
    assign w_v_last = (r_v == r_shadow.v_total - CW'(1));
    assign w_wrap   = w_h_last && w_v_last;
    assign w_apply  = i_en && w_wrap && (r_state == S_PENDING);
    // The first position of a new frame is already evaluated with the
    // freshly applied timing so outputs switch cleanly at (0,0).
    assign w_tim    = w_apply ? r_stage : r_shadow;
    assign w_h_nxt  = w_h_last ? '0 : r_h + CW'(1);
    assign w_v_nxt  = w_h_last ? (w_v_last ? '0 : r_v + CW'(1)) : r_v;

    assign w_hp      = {1'b0, w_h_nxt} + c_LOOK_EXT;
    assign w_h_beg   = {1'b0, w_tim.h_act_start};
    assign w_h_end   = w_h_beg + {1'b0, w_tim.h_act_len};
    assign w_v_beg   = {1'b0, w_tim.v_act_start};
    assign w_v_end   = w_v_beg + {1'b0, w_tim.v_act_len};
    assign w_act_nxt = (w_hp >= w_h_beg) && (w_hp < w_h_end)
                    && ({1'b0, w_v_nxt} >= w_v_beg) && ({1'b0, w_v_nxt} < w_v_end);

    // Advance raster counters and register all position-derived outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_h         <= '0;
            r_v         <= '0;
            r_frame_cnt <= '0;
            r_hs        <= c_HS_POL;
            r_vs        <= c_VS_POL;
            r_act       <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_h_zero    <= 1'b1;
            r_hv_zero   <= 1'b1;
        end else if (i_en) begin
            r_h       <= w_h_nxt;
            r_v       <= w_v_nxt;
            r_hs      <= (w_h_nxt < w_tim.h_sync) ? c_HS_POL : ~c_HS_POL;
            r_vs      <= (w_v_nxt < w_tim.v_sync) ? c_VS_POL : ~c_VS_POL;
            r_act     <= w_act_nxt;
            r_x       <= w_act_nxt ? (w_h_nxt + c_LOOK - w_tim.h_act_start) : '0;
            r_y       <= w_act_nxt ? (w_v_nxt - w_tim.v_act_start) : '0;
            r_h_zero  <= (w_h_nxt == '0);
            r_hv_zero <= (w_h_nxt == '0) && (w_v_nxt == '0);
            if (w_wrap) begin
                r_frame_cnt <= r_frame_cnt + FRAME_CW'(1);
            end
        end
    end

    // Config staging FSM: stage valid writes, hand over at frame boundary
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
            r_stage  <= '0;
            r_shadow <= c_DEFAULT;
        end else begin
            r_err <= i_cfg_wr && !w_cfg_ok;
            if (w_apply) begin
                r_shadow <= r_stage;
            end
            // A write coinciding with the apply cycle lands in staging after
            // the old staged value has been consumed.
            if (w_wr_ok) begin
                r_stage <= w_cfg_in;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_wr_ok) begin
                        r_state <= S_PENDING;
                        r_busy  <= 1'b1;
                    end
                end
                S_PENDING: begin
                    if (!w_wr_ok && w_apply) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_cfg_busy          = r_busy;
    assign o_cfg_err           = r_err;
    assign o_hs                = r_hs;
    assign o_vs                = r_vs;
    assign o_active_video_area = r_act;
    assign o_x                 = r_x;
    assign o_y                 = r_y;
    assign o_frame_cnt         = r_frame_cnt;
    // Strobes mark the current position only while it is about to advance;
    // they are forced low while reset is held.
    assign o_line_start        = i_rst_n & i_en & r_h_zero;
    assign o_frame_start       = i_rst_n & i_en & r_hv_zero;

endmodule
`default_nettype wire
